// File: rtl/ten.sv
// Registered 3-input priority encoder (D2 > D1 > D0) with valid and change pulse.
// Optional "multiple requests" flag is built when TEN_MULTI_EN is defined.
module ten (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic D2,
  input  logic D1,
  input  logic D0,
  output logic Q1,
  output logic Q0,
  output logic V,
  output logic chg
`ifdef TEN_MULTI_EN
  ,
  output logic multi
`endif
);

  logic [1:0] sync_q, sync_d;
  logic [1:0] q_q, q_d;
  logic       v_q, v_d;
  logic       chg_q, chg_d;
  logic       load;

  // Reset asserts at once but releases only after two clean clk edges.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= sync_d;
  end

  always_comb begin
    load  = sync_q[1] & en;
    q_d   = q_q;
    v_d   = v_q;
    chg_d = 1'b0;
    if (load) begin
      v_d = D2 | D1 | D0;
      if (D2)      q_d = 2'b10;
      else if (D1) q_d = 2'b01;
      else         q_d = 2'b00;
      // D0-only and idle share Q=00, so V must take part in the compare.
      chg_d = ({v_d, q_d} != {v_q, q_q});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= 2'b00;
      v_q   <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      v_q   <= v_d;
      chg_q <= chg_d;
    end
  end

  assign Q1  = q_q[1];
  assign Q0  = q_q[0];
  assign V   = v_q;
  assign chg = chg_q;

`ifdef TEN_MULTI_EN
  logic multi_q, multi_d;

  always_comb begin
    multi_d = multi_q;
    if (load) multi_d = (D2 & D1) | (D2 & D0) | (D1 & D0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) multi_q <= 1'b0;
    else        multi_q <= multi_d;
  end

  assign multi = multi_q;
`endif

endmodule

// File: tb/tb_ten.sv
// Self-checking bench for ten: directed vector table, reset/sync corners,
// and randomized stimulus against a behavioural priority-encoder model.
module tb_ten;

  logic clk = 1'b0;
  logic rst_n, en, D2, D1, D0;
  logic Q1, Q0, V, chg;
`ifdef TEN_MULTI_EN
  logic multi;
`endif

  int checks = 0;
  int failures = 0;

  ten dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .D2   (D2),
    .D1   (D1),
    .D0   (D0),
    .Q1   (Q1),
    .Q0   (Q0),
    .V    (V),
    .chg  (chg)
`ifdef TEN_MULTI_EN
    ,
    .multi(multi)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] d;     // {D2,D1,D0}
    logic [2:0] vq;    // expected {V,Q1,Q0}
    logic       chg;
    logic       multi;
  } vec_t;

  vec_t tab[$];

  // behavioural model state
  logic [2:0] m_vq;
  logic       m_chg;
  logic       m_multi;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] vq, input logic c, input logic m);
    check({name, ".vq"}, {1'b0, V, Q1, Q0}, {1'b0, vq});
    check({name, ".chg"}, {3'b0, chg}, {3'b0, c});
`ifdef TEN_MULTI_EN
    check({name, ".multi"}, {3'b0, multi}, {3'b0, m});
`else
    if (m === 1'bx) $display("note: unexpected x");
`endif
  endtask

  task automatic step(input logic e, input logic [2:0] d);
    en = e;
    {D2, D1, D0} = d;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_edge(input logic e, input logic [2:0] d);
    logic [2:0] nvq;
    int idx;
    if (e) begin
      idx = d[2] ? 2 : (d[1] ? 1 : 0);
      nvq = {(d != 3'b000), idx[1:0]};
      m_chg   = (nvq != m_vq);
      m_vq    = nvq;
      m_multi = ($countones(d) >= 2);
    end else begin
      m_chg = 1'b0;
    end
  endfunction

  initial begin
    logic e;
    logic [2:0] d;

    // sweep D0,D1,D2 = 000..111, written here as {D2,D1,D0}
    tab.push_back('{1'b1, 3'b000, 3'b000, 1'b0, 1'b0});
    tab.push_back('{1'b1, 3'b100, 3'b110, 1'b1, 1'b0});
    tab.push_back('{1'b1, 3'b010, 3'b101, 1'b1, 1'b0});
    tab.push_back('{1'b1, 3'b110, 3'b110, 1'b1, 1'b1});
    tab.push_back('{1'b1, 3'b001, 3'b100, 1'b1, 1'b0});
    tab.push_back('{1'b1, 3'b101, 3'b110, 1'b1, 1'b1});
    tab.push_back('{1'b1, 3'b011, 3'b101, 1'b1, 1'b1});
    tab.push_back('{1'b1, 3'b111, 3'b110, 1'b1, 1'b1});
    // hold with en=0
    tab.push_back('{1'b1, 3'b100, 3'b110, 1'b0, 1'b0});
    tab.push_back('{1'b0, 3'b000, 3'b110, 1'b0, 1'b0});
    tab.push_back('{1'b0, 3'b000, 3'b110, 1'b0, 1'b0});
    tab.push_back('{1'b0, 3'b000, 3'b110, 1'b0, 1'b0});
    // change pulse: D0 steady, then D2, then lower bits toggled under D2
    tab.push_back('{1'b1, 3'b001, 3'b100, 1'b1, 1'b0});
    tab.push_back('{1'b1, 3'b001, 3'b100, 1'b0, 1'b0});
    tab.push_back('{1'b1, 3'b001, 3'b100, 1'b0, 1'b0});
    tab.push_back('{1'b1, 3'b100, 3'b110, 1'b1, 1'b0});
    tab.push_back('{1'b1, 3'b110, 3'b110, 1'b0, 1'b1});
    tab.push_back('{1'b1, 3'b101, 3'b110, 1'b0, 1'b1});
    tab.push_back('{1'b1, 3'b111, 3'b110, 1'b0, 1'b1});
    tab.push_back('{1'b1, 3'b100, 3'b110, 1'b0, 1'b0});
    // D0-only versus idle differs only in V
    tab.push_back('{1'b1, 3'b001, 3'b100, 1'b1, 1'b0});
    tab.push_back('{1'b1, 3'b000, 3'b000, 1'b1, 1'b0});
    tab.push_back('{1'b0, 3'b111, 3'b000, 1'b0, 1'b0});

    rst_n = 1'b0;
    en = 1'b0;
    {D2, D1, D0} = 3'b000;
    #12;
    check_outs("reset", 3'b000, 1'b0, 1'b0);

    // release mid-cycle; the first two edges must not sample
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'b100);
    check_outs("sync_edge1", 3'b000, 1'b0, 1'b0);
    step(1'b1, 3'b100);
    check_outs("sync_edge2", 3'b000, 1'b0, 1'b0);
    step(1'b1, 3'b100);
    check_outs("first_sample", 3'b110, 1'b1, 1'b0);

    // asynchronous assert mid-cycle with D2 loaded
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 3'b000);
    check_outs("post_reset_idle", 3'b000, 1'b0, 1'b0);

    foreach (tab[i]) begin
      step(tab[i].en, tab[i].d);
      check_outs($sformatf("vec%0d", i), tab[i].vq, tab[i].chg, tab[i].multi);
    end

    m_vq    = tab[tab.size()-1].vq;
    m_multi = tab[tab.size()-1].multi;
    m_chg   = 1'b0;
    for (int n = 0; n < 300; n++) begin
      e = ($urandom_range(0, 3) != 0);
      d = 3'($urandom_range(0, 7));
      model_edge(e, d);
      step(e, d);
      check_outs($sformatf("rand%0d", n), m_vq, m_chg, m_multi);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
